// File: rtl/mem_access_pkg.sv
// Shared types for the load/store initiator: access sizes, FSM states, lane widths.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      LOAD_DATA = 3'd2,
      STORE     = 3'd3,
      RMW_RD    = 3'd4,
      RMW_WR    = 3'd5,
      ERR_RSP   = 3'd6
   } state_e;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into an existing 32-bit word (little-endian lanes).
module mem_lane_fmt
   import mem_access_pkg::*;
(
   input  logic [1:0]        addr_lo,
   input  size_e             size,
   input  logic              is_unsigned,
   input  logic [WORD_W-1:0] rdata,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] merged
);

   logic [4:0]        shamt;
   logic [WORD_W-1:0] shifted;
   logic [WORD_W-1:0] lane_mask;
   logic [WORD_W-1:0] lane_data;

   assign shamt   = {addr_lo, 3'b000};
   assign shifted = rdata >> shamt;

   always_comb begin
      load_data = rdata;
      lane_mask = '0;
      lane_data = '0;
      case (size)
         SZ_BYTE: begin
            load_data = is_unsigned ? {{(WORD_W-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]}
                                    : {{(WORD_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            lane_mask = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << shamt;
            lane_data = {{(WORD_W-BYTE_W){1'b0}}, wdata[BYTE_W-1:0]} << shamt;
         end
         SZ_HALF: begin
            load_data = is_unsigned ? {{(WORD_W-HALF_W){1'b0}}, shifted[HALF_W-1:0]}
                                    : {{(WORD_W-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            lane_mask = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << shamt;
            lane_data = {{(WORD_W-HALF_W){1'b0}}, wdata[HALF_W-1:0]} << shamt;
         end
         default: begin
            load_data = rdata;
            lane_mask = '1;
            lane_data = wdata;
         end
      endcase
   end

   assign merged = (rdata & ~lane_mask) | lane_data;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide RAM; sub-word stores use read-modify-write.
// Optional build macro MEMACC_RANGE_CHECK_EN rejects addresses beyond 2^ADDR_W bytes.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        ram_wen,
   output logic [31:0] ram_w_addr,
   output logic [31:0] ram_w_data,
   output logic        ram_ren,
   output logic [31:0] ram_r_addr,
   input  logic [31:0] ram_r_data
);

`ifdef MEMACC_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   state_e      state;
   size_e       size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        align_bad;
   logic        range_bad;
   logic [31:0] word_addr;
   logic [31:0] load_data;
   logic [31:0] merged;

   always_comb begin
      case (size_e'(req_size))
         SZ_BYTE: align_bad = 1'b0;
         SZ_HALF: align_bad = req_addr[0];
         SZ_WORD: align_bad = (req_addr[1:0] != 2'b00);
         default: align_bad = 1'b1;
      endcase
   end

   assign range_bad = RANGE_CHECK && ((req_addr >> ADDR_W) != 32'd0);
   assign word_addr = {addr_q[31:2], 2'b00};

   // Async reset forces IDLE, so gating with rst also suppresses a write on the reset edge.
   assign req_ready  = (state == IDLE) && !rst;
   assign ram_ren    = ((state == LOAD) || (state == RMW_RD)) && !rst;
   assign ram_wen    = ((state == STORE) || (state == RMW_WR)) && !rst;
   assign ram_r_addr = ram_ren ? word_addr : 32'd0;
   assign ram_w_addr = ram_wen ? word_addr : 32'd0;
   assign ram_w_data = !ram_wen ? 32'd0 : (state == STORE) ? wdata_q : merged;

   mem_lane_fmt u_fmt (
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .rdata       (ram_r_data),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         size_q    <= SZ_BYTE;
         uns_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: if (req_valid) begin
               size_q  <= size_e'(req_size);
               uns_q   <= req_unsigned;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               // Rejected requests answer straight from IDLE without touching RAM.
               if (align_bad || range_bad) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else if (!req_we)
                  state <= LOAD;
               else if (size_e'(req_size) == SZ_WORD)
                  state <= STORE;
               else
                  state <= RMW_RD;
            end
            LOAD:      state <= LOAD_DATA;
            LOAD_DATA: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= load_data;
               state     <= IDLE;
            end
            STORE: begin
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            RMW_RD:    state <= RMW_WR;
            RMW_WR: begin
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            default:   state <= IDLE;
         endcase
      end
   end

endmodule
